// File: rtl/digit_serial_alu_if.sv
// digit_serial_alu_if
//   Request/response bundle for the digit-serial ALU.
//   master modport: the requester (drives in_valid/command/a/b/out_ready).
//   slave  modport: the ALU (drives in_ready/out_valid/result/flags).
//
//   in_valid  : operation request        in_ready  : ALU idle, accepts request
//   command   : 3-bit opcode             a, b      : WIDTH-bit operands
//   out_valid : result and flags valid   out_ready : requester takes result
//   result    : WIDTH-bit result         carryout, zero, overflow : flags
interface digit_serial_alu_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       command;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carryout;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, command, a, b, out_ready,
    input  in_ready, out_valid, result, carryout, zero, overflow
  );

  modport slave (
    input  in_valid, command, a, b, out_ready,
    output in_ready, out_valid, result, carryout, zero, overflow
  );
endinterface

// File: rtl/digit_serial_alu.sv
// digit_serial_alu
//   Multi-cycle ALU that processes WIDTH-bit operands DIGIT bits per clock,
//   low digit first. Carry and zero are chained across cycles exactly as a
//   ripple ALU chains them across bit positions. One operation in flight.
//
//   Parameters: WIDTH (operand width, multiple of DIGIT), DIGIT (bits/cycle).
//   Ports:
//     clk   : clock, rising edge
//     reset : synchronous, active-high
//     bus   : digit_serial_alu_if.slave (valid/ready request and response)
//   Commands: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
//
//   Optional feature: define DSALU_SLT_EN to make command 3 a true
//   set-less-than (result = signed a < b). Without it, command 3 is SUB.
module digit_serial_alu #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input logic               clk,
  input logic               reset,
  digit_serial_alu_if.slave bus
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    CMD_ADD  = 3'd0,
    CMD_SUB  = 3'd1,
    CMD_XOR  = 3'd2,
    CMD_SLT  = 3'd3,
    CMD_AND  = 3'd4,
    CMD_NAND = 3'd5,
    CMD_NOR  = 3'd6,
    CMD_OR   = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e state, state_nx;

  // Operand/working registers
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  cmd_e             cmd_q;
  logic             carry;
  logic             zacc;
  logic [CNT_W-1:0] cnt;

  // Registered outputs
  logic [WIDTH-1:0] result_q;
  logic             carry_q, zero_q, ovf_q;

  // Per-digit datapath
  logic             is_arith, invert, last;
  logic [DIGIT-1:0] da, dbx, digit;
  logic [DIGIT:0]   sum;
  logic             c_out, c_msb_in, ovf;
  logic             zacc_nx;
  logic [WIDTH+DIGIT-1:0] res_cat;
  logic [WIDTH-1:0] res_shift;

  // Values loaded into the output registers on the last RUN cycle
  logic [WIDTH-1:0] fin_result;
  logic             fin_carry, fin_ovf, fin_zero;

  assign last = (cnt == CNT_W'(N - 1));

  // ---------------- FSM ----------------
  // NOTE: all sequential state uses non-blocking (<=) assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // NOTE: the next-state default is assigned first so no path leaves
  // state_nx unassigned, which would infer a latch.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (bus.in_valid)  state_nx = S_RUN;
      S_RUN:  if (last)          state_nx = S_DONE;
      S_DONE: if (bus.out_ready) state_nx = S_IDLE;
      default:                   state_nx = S_IDLE;
    endcase
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.result    = result_q;
  assign bus.carryout  = carry_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;

  // ---------------- digit datapath ----------------
  always_comb begin
    is_arith = (cmd_q == CMD_ADD) || (cmd_q == CMD_SUB) || (cmd_q == CMD_SLT);
    // SUB and SLT both compute a + ~b + 1; the +1 is the initial carry.
    invert   = (cmd_q != CMD_ADD);
    da       = a_sr[DIGIT-1:0];
    dbx      = b_sr[DIGIT-1:0] ^ {DIGIT{invert & is_arith}};
    sum      = {1'b0, da} + {1'b0, dbx} + {{DIGIT{1'b0}}, carry};
    c_out    = sum[DIGIT];
    // Carry into the top bit recovered from the top bit's own sum equation.
    c_msb_in = da[DIGIT-1] ^ dbx[DIGIT-1] ^ sum[DIGIT-1];
    ovf      = c_out ^ c_msb_in;

    digit = sum[DIGIT-1:0];
    unique case (cmd_q)
      CMD_XOR:  digit = da ^ b_sr[DIGIT-1:0];
      CMD_AND:  digit = da & b_sr[DIGIT-1:0];
      CMD_NAND: digit = ~(da & b_sr[DIGIT-1:0]);
      CMD_NOR:  digit = ~(da | b_sr[DIGIT-1:0]);
      CMD_OR:   digit = da | b_sr[DIGIT-1:0];
      default:  digit = sum[DIGIT-1:0];
    endcase

    zacc_nx = zacc | (|digit);
    // Digits enter from the MSB side; after N shifts the first digit sits at
    // bit 0. The concatenation keeps this legal when DIGIT == WIDTH.
    res_cat   = {digit, res_sr};
    res_shift = res_cat[WIDTH+DIGIT-1:DIGIT];
  end

  always_comb begin
    fin_result = res_shift;
    fin_carry  = is_arith & c_out;
    fin_ovf    = is_arith & ovf;
    fin_zero   = ~zacc_nx;
`ifdef DSALU_SLT_EN
    if (cmd_q == CMD_SLT) begin
      // Signed less-than: sign of (a - b) corrected by its overflow.
      fin_result = WIDTH'(sum[DIGIT-1] ^ ovf);
      fin_carry  = 1'b0;
      fin_ovf    = 1'b0;
      fin_zero   = ~(sum[DIGIT-1] ^ ovf);
    end
`endif
  end

  // Control counter and output registers: these have a defined reset value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (bus.in_valid) cnt <= '0;
        S_RUN: begin
          cnt <= cnt + 1'b1;
          if (last) begin
            result_q <= fin_result;
            carry_q  <= fin_carry;
            zero_q   <= fin_zero;
            ovf_q    <= fin_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the operand shift registers are deliberately not reset; every
  // operation reloads them on accept, and reset only needs the FSM, counter
  // and visible outputs to be defined.
  always_ff @(posedge clk) begin
    unique case (state)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_sr   <= bus.a;
          b_sr   <= bus.b;
          cmd_q  <= cmd_e'(bus.command);
          carry  <= (bus.command == CMD_SUB) || (bus.command == CMD_SLT);
          zacc   <= 1'b0;
          res_sr <= '0;
        end
      end
      S_RUN: begin
        a_sr   <= a_sr >> DIGIT;
        b_sr   <= b_sr >> DIGIT;
        res_sr <= res_shift;
        carry  <= c_out;
        zacc   <= zacc_nx;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_digit_serial_alu.sv
// tb_digit_serial_alu
//   Directed self-checking bench for digit_serial_alu (WIDTH=32, DIGIT=4).
//   Expected values are hand-computed constants. Honours DSALU_SLT_EN.
module tb_digit_serial_alu;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  digit_serial_alu_if #(.WIDTH(WIDTH)) bus ();

  digit_serial_alu #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request and hold it until the accepting edge.
  task automatic issue(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
    bus.command  = cmd;
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges after accept until out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [2:0] cmd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ec,
                        input logic ez, input logic eo);
    int lat;
    issue(cmd, a, b);
    wait_done(lat);
    check({tag, "_latency"}, 32'(lat), 32'(N));
    check({tag, "_result"},  bus.result, er);
    check({tag, "_carry"},   32'(bus.carryout), 32'(ec));
    check({tag, "_zero"},    32'(bus.zero), 32'(ez));
    check({tag, "_ovf"},     32'(bus.overflow), 32'(eo));
    release_out();
    check({tag, "_idle"},    32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.command   = 3'd0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_result",    bus.result, 32'h0);
    check("rst_zero",      32'(bus.zero), 32'd1);

    // Arithmetic
    run_op("add_ovf", 3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1);
    run_op("sub_eq",  3'd1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0);
`ifdef DSALU_SLT_EN
    run_op("slt",     3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0);
`else
    run_op("slt",     3'd3, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
`endif

    // Logic ops
    run_op("xor",  3'd2, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0);
    run_op("and",  3'd4, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0);
    run_op("nand", 3'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0);
    run_op("nor",  3'd6, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0, 1'b0);
    run_op("or",   3'd7, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
    run_op("xor_zero", 3'd2, 32'h12345678, 32'h12345678, 32'h00000000, 1'b0, 1'b1, 1'b0);

    // Back-pressure: DONE holds, new requests ignored
    issue(3'd0, 32'h00000001, 32'h00000002);
    wait_done(lat);
    check("bp_latency", 32'(lat), 32'(N));
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.command  = 3'd7;
      bus.a        = 32'hDEAD0000 + 32'(i);
      bus.b        = 32'h0000BEEF;
      @(posedge clk); #1;
      check("bp_result",    bus.result, 32'h00000003);
      check("bp_in_ready",  32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    release_out();
    check("bp_release_idle", 32'(bus.in_ready), 32'd1);
    check("bp_release_ov",   32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check("bp_still_idle",   32'(bus.in_ready), 32'd1);
    check("bp_result_kept",  bus.result, 32'h00000003);

    // Reset in the middle of RUN
    issue(3'd0, 32'h00000010, 32'h00000020);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mrst_in_ready",  32'(bus.in_ready), 32'd1);
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_result",    bus.result, 32'h0);
    check("mrst_zero",      32'(bus.zero), 32'd1);
    repeat (N + 2) @(posedge clk);
    #1;
    check("mrst_no_done",   32'(bus.out_valid), 32'd0);
    run_op("add_after_rst", 3'd0, 32'h00000002, 32'h00000003, 32'h00000005, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
